condicionador_botoes: RTL and testbench
=======================================

Name: condicionador_botoes

Overview:
Input conditioner that sits directly upstream of the game datapath and control unit. It synchronises and debounces the raw player buttons, rejects non-one-hot combinations, and hands over one clean play: a 1-cycle tem_jogada pulse with a registered one-hot jogada code. It fires once per physical press and re-arms only after a debounced release.

Parameters:
N_BOTOES, 4, number of buttons and width of botoes/jogada.
DEBOUNCE_CICLOS, 3, consecutive identical synchronised samples required to accept a press or a release. Must be >= 2.

Ports:
clock  input  1  system clock (10 kHz in the game build).
reset  input  1  synchronous, active-high reset.
botoes  input  N_BOTOES  raw asynchronous button levels.
habilita  input  1  from the control unit; high = a play is being awaited.
tem_jogada  output  1  registered 1-cycle pulse per accepted play.
jogada  output  N_BOTOES  registered one-hot code of the last accepted play; held until the next accepted play.
erro_multiplo  output  1  1-cycle pulse on a rejected multi-button press (see Optional Feature).
db_estado  output  4  current FSM state code, for the 7-segment debug display.

Behaviour:
- Synchroniser: two flops, sync1 then sync2, give botoes_s. Both flops clear on reset.
- Counter cnt: width $clog2(DEBOUNCE_CICLOS)+1. Register cand (N_BOTOES) holds the press candidate.
- Reset values: FSM=ESPERA_SOLTAR, cnt=0, cand=0, tem_jogada=0, jogada=0, erro_multiplo=0, db_estado=4'h3.
- Resetting into ESPERA_SOLTAR is deliberate: a button held through reset is never reported as a play.
- States and db_estado codes: OCIOSO=0, CONTANDO=1, PULSO=2, ESPERA_SOLTAR=3.
- OCIOSO:
  - botoes_s != 0: cand<=botoes_s, cnt<=1, go to CONTANDO.
  - Otherwise stay.
- CONTANDO:
  - botoes_s==0: go to OCIOSO. This is a glitch and produces no output.
  - botoes_s nonzero but != cand: cand<=botoes_s, cnt<=1, stay.
  - botoes_s==cand and cnt<DEBOUNCE_CICLOS-1: cnt++.
  - botoes_s==cand and cnt==DEBOUNCE_CICLOS-1: decision edge.
    - cand one-hot and habilita=1: jogada<=cand, tem_jogada<=1, go to PULSO.
    - cand one-hot and habilita=0: press ignored; go to ESPERA_SOLTAR with cnt<=0.
    - cand not one-hot: press rejected; go to ESPERA_SOLTAR with cnt<=0. erro_multiplo pulses if the feature is enabled.
- PULSO: tem_jogada<=0, cnt<=0, go to ESPERA_SOLTAR. tem_jogada is therefore high for exactly one cycle.
- ESPERA_SOLTAR:
  - botoes_s!=0: cnt<=0.
  - botoes_s==0: cnt++. When cnt reaches DEBOUNCE_CICLOS-1 with a zero sample, go to OCIOSO.
- Latency: let E0 be the first rising edge that samples a new stable press. tem_jogada is high from edge E0+DEBOUNCE_CICLOS+1 to edge E0+DEBOUNCE_CICLOS+2. With the default of 3, it rises at E0+4.
- Re-arm: a release must be stable for DEBOUNCE_CICLOS synchronised samples before the next press can start counting.
- habilita is sampled only at the decision edge. Changes at any other time have no effect.
- Reset mid-operation (any state) applies the reset values at the next edge. A pending pulse is dropped.
- A single button held indefinitely produces exactly one tem_jogada.

Optional Feature:
Macro CONDICIONADOR_ERRO_MULTIPLO_EN.
- Defined: erro_multiplo is registered. It is high for exactly one cycle on the decision edge's following cycle when cand is not one-hot. This holds regardless of habilita.
- Undefined: erro_multiplo is tied to 0. Rejection behaviour is otherwise identical.

Test Plan:
1. Reset, then botoes=0000 for 10 cycles -> db_estado 3 then 0 after 3 cycles; tem_jogada=0; jogada=0000.
2. habilita=1, botoes=0001 held for 10 cycles from a negedge -> exactly one tem_jogada pulse, 4 edges after first sampling; jogada=0001 and held after release.
3. habilita=1, botoes=0010 for 2 cycles only, then 0000 -> no tem_jogada; FSM returns to OCIOSO; jogada unchanged.
4. habilita=1, botoes=0101 held for 10 cycles -> no tem_jogada; jogada unchanged; erro_multiplo pulses once with the macro defined and stays 0 without it.
5. habilita=0, botoes=0100 held for 10 cycles; then habilita=1 while still held -> no pulse. After release for ≥3 cycles, re-press 0100 -> one pulse, jogada=0100.
6. Press 1000, assert reset for 1 cycle on the decision edge, keep 1000 held -> no tem_jogada until release ≥3 cycles and re-press; db_estado=3 immediately after reset.

Source files
------------

// File: rtl/condicionador_botoes.sv
// -----------------------------------------------------------------------------
// condicionador_botoes
//
// Purpose:
//   Button conditioner in front of the game datapath and control unit.
//   It synchronises the raw buttons, debounces them and rejects combinations
//   that are not one-hot. Each physical press hands over at most one clean
//   play, seen as a 1-cycle tem_jogada pulse with a registered one-hot jogada
//   code. A new press is only considered after a debounced release.
//
// Ports:
//   clock         system clock
//   reset         synchronous, active-high reset
//   botoes        raw asynchronous button levels (N_BOTOES bits)
//   habilita      high while the control unit is waiting for a play
//   tem_jogada    registered 1-cycle pulse for each accepted play
//   jogada        registered one-hot code of the last accepted play
//   erro_multiplo 1-cycle pulse when a multi-button press is rejected
//   db_estado     current FSM state code for the debug display
//
// Configuration:
//   CONDICIONADOR_ERRO_MULTIPLO_EN - when defined, erro_multiplo is a
//   registered pulse. Otherwise it is tied to 0.
// -----------------------------------------------------------------------------
module condicionador_botoes #(
    parameter int N_BOTOES        = 4,
    parameter int DEBOUNCE_CICLOS = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes,
    input  logic                habilita,
    output logic                tem_jogada,
    output logic [N_BOTOES-1:0] jogada,
    output logic                erro_multiplo,
    output logic [3:0]          db_estado
);

    localparam int CW = $clog2(DEBOUNCE_CICLOS) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);
    localparam logic [CW-1:0] CNT_UM  = CW'(1);

    typedef enum logic [1:0] {
        OCIOSO        = 2'd0,
        CONTANDO      = 2'd1,
        PULSO         = 2'd2,
        ESPERA_SOLTAR = 2'd3
    } estado_t;

    // Two-stage synchroniser on the raw asynchronous levels.
    logic [N_BOTOES-1:0] sync1_q;
    logic [N_BOTOES-1:0] sync2_q;
    logic [N_BOTOES-1:0] botoes_s;

    estado_t             estado_q, estado_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [N_BOTOES-1:0] cand_q, cand_d;
    logic [N_BOTOES-1:0] jogada_q, jogada_d;
    logic                tem_jogada_q, tem_jogada_d;
    logic                cand_um_quente;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= botoes;
            sync2_q <= sync1_q;
        end
    end

    assign botoes_s = sync2_q;

    // Exactly one bit set: nonzero and clearing the lowest set bit gives zero.
    assign cand_um_quente = (cand_q != '0) &&
                            ((cand_q & (cand_q - N_BOTOES'(1))) == '0);

`ifdef CONDICIONADOR_ERRO_MULTIPLO_EN
    logic erro_q, erro_d;
`endif

    always_comb begin
        estado_d     = estado_q;
        cnt_d        = cnt_q;
        cand_d       = cand_q;
        jogada_d     = jogada_q;
        tem_jogada_d = 1'b0;
`ifdef CONDICIONADOR_ERRO_MULTIPLO_EN
        erro_d       = 1'b0;
`endif
        case (estado_q)
            OCIOSO: begin
                if (botoes_s != '0) begin
                    cand_d   = botoes_s;
                    cnt_d    = CNT_UM;
                    estado_d = CONTANDO;
                end
            end
            CONTANDO: begin
                if (botoes_s == '0) begin
                    // Short glitch: drop it silently.
                    estado_d = OCIOSO;
                end else if (botoes_s != cand_q) begin
                    // Pattern changed while counting: restart on the new one.
                    cand_d = botoes_s;
                    cnt_d  = CNT_UM;
                end else if (cnt_q < CNT_MAX) begin
                    cnt_d = cnt_q + CNT_UM;
                end else begin
                    // Decision edge: the candidate is stable long enough.
                    cnt_d = '0;
                    if (cand_um_quente && habilita) begin
                        jogada_d     = cand_q;
                        tem_jogada_d = 1'b1;
                        estado_d     = PULSO;
                    end else begin
                        estado_d = ESPERA_SOLTAR;
`ifdef CONDICIONADOR_ERRO_MULTIPLO_EN
                        erro_d   = !cand_um_quente;
`endif
                    end
                end
            end
            PULSO: begin
                cnt_d    = '0;
                estado_d = ESPERA_SOLTAR;
            end
            ESPERA_SOLTAR: begin
                // Re-arm only after a release that is stable for the
                // full debounce window.
                if (botoes_s != '0) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    cnt_d    = '0;
                    estado_d = OCIOSO;
                end else begin
                    cnt_d = cnt_q + CNT_UM;
                end
            end
            default: begin
                estado_d = ESPERA_SOLTAR;
                cnt_d    = '0;
            end
        endcase
    end

    // Reset lands in ESPERA_SOLTAR so a button held through reset is
    // never reported as a play.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q     <= ESPERA_SOLTAR;
            cnt_q        <= '0;
            cand_q       <= '0;
            jogada_q     <= '0;
            tem_jogada_q <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            cnt_q        <= cnt_d;
            cand_q       <= cand_d;
            jogada_q     <= jogada_d;
            tem_jogada_q <= tem_jogada_d;
        end
    end

`ifdef CONDICIONADOR_ERRO_MULTIPLO_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            erro_q <= 1'b0;
        end else begin
            erro_q <= erro_d;
        end
    end
    assign erro_multiplo = erro_q;
`else
    assign erro_multiplo = 1'b0;
`endif

    assign tem_jogada = tem_jogada_q;
    assign jogada     = jogada_q;
    assign db_estado  = {2'b00, estado_q};

endmodule

// File: tb/tb_condicionador_botoes.sv
module tb_condicionador_botoes;

    localparam int N  = 4;
    localparam int DC = 3;
`ifdef CONDICIONADOR_ERRO_MULTIPLO_EN
    localparam int ERR_EXP = 1;
`else
    localparam int ERR_EXP = 0;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic [N-1:0] botoes;
    logic         habilita;
    logic         tem_jogada;
    logic [N-1:0] jogada;
    logic         erro_multiplo;
    logic [3:0]   db_estado;

    condicionador_botoes #(.N_BOTOES(N), .DEBOUNCE_CICLOS(DC)) dut (
        .clock         (clock),
        .reset         (reset),
        .botoes        (botoes),
        .habilita      (habilita),
        .tem_jogada    (tem_jogada),
        .jogada        (jogada),
        .erro_multiplo (erro_multiplo),
        .db_estado     (db_estado)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int pulse_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        int           due;
        logic [N-1:0] val;
    } exp_t;

    exp_t q_jog[$];
    int   q_err[$];

    // Reference model state: the pipeline of raw samples, whether a release
    // has been seen long enough (armed), and the length of the current run of
    // identical nonzero samples.
    logic [N-1:0] d1 = '0, d2 = '0, run_val = '0, exp_jog = '0;
    int           zero_run = 0, run_len = 0, cyc = 0, exp_state = 3;
    bit           armed = 1'b0, skip = 1'b0;

    function automatic bit one_hot(logic [N-1:0] v);
        return $countones(v) == 1;
    endfunction

    task automatic check(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clock) begin
        logic [N-1:0] s;
        cyc++;
        if (reset) begin
            d1 = '0; d2 = '0;
            armed = 1'b0; skip = 1'b0;
            zero_run = 0; run_len = 0;
            exp_jog = '0;
            q_jog.delete();
            q_err.delete();
        end else begin
            s  = d2;
            d2 = d1;
            d1 = botoes;
            if (skip) begin
                skip = 1'b0;
            end else if (!armed) begin
                if (s == '0) zero_run++;
                else         zero_run = 0;
                if (zero_run >= DC) begin
                    armed   = 1'b1;
                    run_len = 0;
                end
            end else begin
                if (s == '0)                          run_len = 0;
                else if (run_len > 0 && s == run_val) run_len++;
                else begin
                    run_val = s;
                    run_len = 1;
                end
                if (run_len == DC) begin
                    if (one_hot(s) && habilita) begin
                        exp_jog = s;
                        q_jog.push_back('{cyc, s});
                        skip = 1'b1;
                    end else if (!one_hot(s)) begin
                        q_err.push_back(cyc);
                    end
                    armed    = 1'b0;
                    zero_run = 0;
                    run_len  = 0;
                end
            end
        end
        exp_state = skip ? 2 : (!armed ? 3 : (run_len > 0 ? 1 : 0));
    end

    // Monitor: compares outputs half a cycle after each active edge.
    always @(negedge clock) begin
        if (cyc > 0) begin
            if (tem_jogada) begin
                pulse_cnt++;
                tests++;
                if (q_jog.size() > 0 && q_jog[0].due == cyc && q_jog[0].val == jogada) begin
                    void'(q_jog.pop_front());
                end else begin
                    fails++;
                    $display("FAIL pulse: unexpected tem_jogada jogada=%b at cycle %0d (pending %0d)",
                             jogada, cyc, q_jog.size());
                    if (q_jog.size() > 0 && q_jog[0].due == cyc) void'(q_jog.pop_front());
                end
            end else if (q_jog.size() > 0 && q_jog[0].due <= cyc) begin
                tests++;
                fails++;
                $display("FAIL pulse: missing tem_jogada got 0 expected 1 jogada=%b at cycle %0d",
                         q_jog[0].val, cyc);
                void'(q_jog.pop_front());
            end
            if (erro_multiplo) err_cnt++;
`ifdef CONDICIONADOR_ERRO_MULTIPLO_EN
            if (erro_multiplo) begin
                tests++;
                if (q_err.size() > 0 && q_err[0] == cyc) begin
                    void'(q_err.pop_front());
                end else begin
                    fails++;
                    $display("FAIL erro: unexpected erro_multiplo at cycle %0d", cyc);
                end
            end else if (q_err.size() > 0 && q_err[0] <= cyc) begin
                tests++;
                fails++;
                $display("FAIL erro: missing erro_multiplo got 0 expected 1 at cycle %0d", cyc);
                void'(q_err.pop_front());
            end
`else
            check("erro_tied", int'(erro_multiplo), 0);
`endif
            check("jogada", int'(jogada), int'(exp_jog));
            check("db_estado", int'(db_estado), exp_state);
        end
    end

    task automatic apply(logic [N-1:0] b, logic h, int n);
        botoes   = b;
        habilita = h;
        repeat (n) @(negedge clock);
    endtask

    initial begin
        int p0, e0;
        reset    = 1'b1;
        botoes   = '0;
        habilita = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_db_estado", int'(db_estado), 3);
        check("reset_tem_jogada", int'(tem_jogada), 0);
        check("reset_jogada", int'(jogada), 0);
        reset = 1'b0;

        // 1: idle after reset
        apply('0, 1'b0, 10);
        check("t1_ocioso", int'(db_estado), 0);

        // 2: clean single press, one pulse
        p0 = pulse_cnt;
        apply(4'b0001, 1'b1, 10);
        apply('0, 1'b1, 6);
        check("t2_pulses", pulse_cnt - p0, 1);
        check("t2_jogada", int'(jogada), 1);

        // 3: short press is a glitch
        p0 = pulse_cnt;
        apply(4'b0010, 1'b1, 2);
        apply('0, 1'b1, 6);
        check("t3_pulses", pulse_cnt - p0, 0);
        check("t3_jogada", int'(jogada), 1);

        // 4: multi-button press rejected
        p0 = pulse_cnt;
        e0 = err_cnt;
        apply(4'b0101, 1'b1, 10);
        apply('0, 1'b1, 6);
        check("t4_pulses", pulse_cnt - p0, 0);
        check("t4_erro", err_cnt - e0, ERR_EXP);

        // 5: press while disabled, enable while still held, then re-press
        p0 = pulse_cnt;
        apply(4'b0100, 1'b0, 10);
        apply(4'b0100, 1'b1, 6);
        apply('0, 1'b1, 6);
        check("t5_ignored", pulse_cnt - p0, 0);
        apply(4'b0100, 1'b1, 10);
        apply('0, 1'b1, 6);
        check("t5_pulses", pulse_cnt - p0, 1);
        check("t5_jogada", int'(jogada), 4);

        // 6: reset on the decision edge drops the play
        p0 = pulse_cnt;
        apply(4'b1000, 1'b1, 4);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("t6_db_estado", int'(db_estado), 3);
        apply(4'b1000, 1'b1, 10);
        check("t6_held", pulse_cnt - p0, 0);
        apply('0, 1'b1, 6);
        apply(4'b1000, 1'b1, 10);
        apply('0, 1'b1, 6);
        check("t6_pulses", pulse_cnt - p0, 1);

        // Random segments against the reference model
        for (int i = 0; i < 250; i++) begin
            int r;
            logic [N-1:0] b;
            r = $urandom_range(0, 9);
            if (r < 4)      b = '0;
            else if (r < 8) b = N'(1) << $urandom_range(0, N - 1);
            else            b = N'($urandom_range(1, (1 << N) - 1));
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
            end
            apply(b, 1'($urandom_range(0, 1)), $urandom_range(1, 8));
        end
        apply('0, 1'b0, 10);
        check("end_pending_pulses", q_jog.size(), 0);
`ifdef CONDICIONADOR_ERRO_MULTIPLO_EN
        check("end_pending_erro", q_err.size(), 0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
